// File: rtl/dot_window_accumulator.sv
// dot_window_accumulator
//   Downstream stage of the bit-serial dot-product convolutor. Sums a window
//   of NUM_TERMS unsigned IN_W-bit results into a saturating SUM_W-bit total
//   and presents it over a valid/ready handshake.
//
// Ports:
//   clk, reset      rising-edge clock; asynchronous active-high reset
//   clear           synchronous abort of the current window (wins over all)
//   in_valid/in_ready/in_data     upstream handshake, in_ready from state only
//   out_valid/out_ready/out_sum/out_ovf  downstream handshake; out_ovf marks
//                   a window that saturated at least once
//
// Optional: define CONV_THRESH_EN to add input thresh and output out_hit
//   (registered out_sum >= thresh at the final accept).
module dot_window_accumulator #(
  parameter int IN_W      = 4,
  parameter int NUM_TERMS = 4,
  parameter int SUM_W     = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [SUM_W-1:0] out_sum,
  output logic             out_ovf,
  input  logic             out_ready
`ifdef CONV_THRESH_EN
  ,
  input  logic [SUM_W-1:0] thresh,
  output logic             out_hit
`endif
);

  localparam int CNT_W = 4;
  localparam int EXT_W = SUM_W + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_TERMS - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t           r_state;
  logic [SUM_W-1:0] r_acc;
  logic [CNT_W-1:0] r_count;
  logic             r_ovf;
  logic             r_out_valid;
  logic [SUM_W-1:0] r_out_sum;
  logic             r_out_ovf;

  logic [EXT_W-1:0] w_sum;
  logic [SUM_W-1:0] w_sat;
  logic             w_ovf;

  // One extra bit catches the carry; a carry means the true sum overflowed.
  assign w_sum = {1'b0, r_acc} + EXT_W'(in_data);
  assign w_sat = w_sum[SUM_W] ? '1 : w_sum[SUM_W-1:0];
  assign w_ovf = r_ovf | w_sum[SUM_W];

  assign in_ready  = (r_state != HOLD);
  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign out_ovf   = r_out_ovf;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_count     <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_ovf   <= 1'b0;
    end else if (clear) begin
      // Abort leaves the last presented total/flag untouched.
      r_state     <= IDLE;
      r_acc       <= '0;
      r_count     <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE, ACCUM: begin
          if (in_valid) begin
            r_acc   <= w_sat;
            r_count <= r_count + 1'b1;
            r_ovf   <= w_ovf;
            if (r_count == LAST) begin
              r_out_sum   <= w_sat;
              r_out_ovf   <= w_ovf;
              r_out_valid <= 1'b1;
              r_state     <= HOLD;
            end else begin
              r_state <= ACCUM;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            r_acc       <= '0;
            r_count     <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef CONV_THRESH_EN
  logic r_hit;
  assign out_hit = r_hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hit <= 1'b0;
    end else if (!clear && r_state != HOLD && in_valid && r_count == LAST) begin
      r_hit <= (w_sat >= thresh);
    end
  end
`endif

endmodule

// File: tb/tb_dot_window_accumulator.sv
module tb_dot_window_accumulator;

  localparam int NT = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       clear;
  logic       in_valid;
  logic [3:0] in_data;
  logic       out_ready;

  logic       in_ready6, out_valid6, out_ovf6;
  logic [5:0] out_sum6;
  logic       in_ready5, out_valid5, out_ovf5;
  logic [4:0] out_sum5;
`ifdef CONV_THRESH_EN
  logic [5:0] thresh;
  logic       out_hit6, out_hit5;
`endif

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: a window is just a running integer total of accepted
  // terms; the presented value is min(total, 2^W-1), overflow is total > max.
  int m_terms, m_total;
  bit m_hold;
  int m_sum6, m_sum5;
  bit m_ovf6, m_ovf5;
`ifdef CONV_THRESH_EN
  bit m_hit;
`endif

  always #10 clk = ~clk;

  dot_window_accumulator #(.IN_W(4), .NUM_TERMS(NT), .SUM_W(6)) dut6 (
    .clk(clk), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready6),
    .out_valid(out_valid6), .out_sum(out_sum6), .out_ovf(out_ovf6),
    .out_ready(out_ready)
`ifdef CONV_THRESH_EN
    , .thresh(thresh), .out_hit(out_hit6)
`endif
  );

  dot_window_accumulator #(.IN_W(4), .NUM_TERMS(NT), .SUM_W(5)) dut5 (
    .clk(clk), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready5),
    .out_valid(out_valid5), .out_sum(out_sum5), .out_ovf(out_ovf5),
    .out_ready(out_ready)
`ifdef CONV_THRESH_EN
    , .thresh(thresh[4:0]), .out_hit(out_hit5)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_terms = 0; m_total = 0; m_hold = 0;
    m_sum6 = 0; m_sum5 = 0; m_ovf6 = 0; m_ovf5 = 0;
`ifdef CONV_THRESH_EN
    m_hit = 0;
`endif
  endtask

  task automatic check_outputs();
    check("out_valid6", out_valid6, m_hold);
    check("out_valid5", out_valid5, m_hold);
    check("out_sum6",   out_sum6,   m_sum6);
    check("out_sum5",   out_sum5,   m_sum5);
    check("out_ovf6",   out_ovf6,   m_ovf6);
    check("out_ovf5",   out_ovf5,   m_ovf5);
`ifdef CONV_THRESH_EN
    check("out_hit6",   out_hit6,   m_hit);
`endif
  endtask

  // Inputs are already applied; predict the coming edge, clock it, compare.
  task automatic cycle();
    check("in_ready6", in_ready6, !m_hold);
    check("in_ready5", in_ready5, !m_hold);
    if (clear) begin
      m_terms = 0; m_total = 0; m_hold = 0;
    end else if (!m_hold) begin
      if (in_valid) begin
        m_total += int'(in_data);
        m_terms++;
        if (m_terms == NT) begin
          m_hold = 1;
          m_sum6 = (m_total > 63) ? 63 : m_total;
          m_ovf6 = (m_total > 63);
          m_sum5 = (m_total > 31) ? 31 : m_total;
          m_ovf5 = (m_total > 31);
`ifdef CONV_THRESH_EN
          m_hit = (m_sum6 >= int'(thresh));
`endif
          m_terms = 0; m_total = 0;
        end
      end
    end else if (out_ready) begin
      m_hold = 0;
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic drive(input bit v, input int d, input bit ordy, input bit clr);
    in_valid  = v;
    in_data   = 4'(d);
    out_ready = ordy;
    clear     = clr;
    cycle();
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
`ifdef CONV_THRESH_EN
    thresh = 6'd10;
`endif
    model_reset();
    #13;
    check_outputs();
    check("rst_in_ready", in_ready6, 1'b1);
    #12 reset = 1'b0;
    @(posedge clk); #1;

    // Basic window with immediate handshake and one bubble.
    drive(1, 3, 1, 0); drive(1, 5, 1, 0); drive(1, 2, 1, 0); drive(1, 6, 1, 0);
    drive(1, 1, 1, 0); drive(1, 1, 1, 0); drive(0, 0, 1, 0);

    // Saturation on the narrow instance, then a clean window.
    drive(0, 0, 0, 0); m_terms = m_terms; // window restarted from IDLE
    for (int i = 0; i < 4; i++) drive(1, 15, 0, 0);
    drive(0, 0, 1, 0);
    for (int i = 0; i < 4; i++) drive(1, 1, 0, 0);
    drive(0, 0, 1, 0);

    // Backpressure with upstream pushing 9 while held.
    drive(1, 3, 0, 0); drive(1, 5, 0, 0); drive(1, 2, 0, 0); drive(1, 6, 0, 0);
    for (int i = 0; i < 5; i++) drive(1, 9, 0, 0);
    drive(0, 0, 1, 0);
    for (int i = 0; i < 4; i++) drive(1, 1, 0, 0);
    drive(0, 0, 1, 0);

    // Clear mid-window and clear while holding.
    drive(1, 7, 0, 0); drive(1, 7, 0, 0); drive(0, 0, 0, 1);
    for (int i = 0; i < 4; i++) drive(1, 1, 0, 0);
    drive(0, 0, 0, 0);
    drive(1, 4, 1, 1);
    drive(0, 0, 0, 0);

`ifdef CONV_THRESH_EN
    thresh = 6'd16;
    drive(1, 3, 0, 0); drive(1, 5, 0, 0); drive(1, 2, 0, 0); drive(1, 6, 0, 0);
    drive(0, 0, 1, 0);
    thresh = 6'd10;
`endif

    // Asynchronous reset while holding a window.
    drive(1, 3, 0, 0); drive(1, 5, 0, 0); drive(1, 2, 0, 0); drive(1, 6, 0, 0);
    drive(0, 0, 0, 0);
    #3 reset = 1'b1;
    #2;
    model_reset();
    check_outputs();
    check("arst_in_ready", in_ready6, 1'b1);
    #3 reset = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) drive(1, 2, 1, 0);
    drive(0, 0, 1, 0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
`ifdef CONV_THRESH_EN
      thresh = 6'($urandom_range(0, 63));
`endif
      drive(($urandom_range(0, 99) < 70), int'($urandom_range(0, 15)),
            ($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 3));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
